// File: rtl/game_sequencer_pkg.sv
// Shared state encoding and default intro timings for the runner's game director.
package game_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    COUNTDOWN = 3'd1,
    LOGO_FADE = 3'd2,
    SLIDE     = 3'd3,
    PLAY      = 3'd4,
    GAME_OVER = 3'd5,
    PAUSE     = 3'd6
  } game_state_t;

  localparam int DEF_COUNT_INIT = 5;
  localparam int DEF_FADE_STEP  = 30;
  localparam int DEF_FADE_END   = 640;
  localparam int DEF_SLIDE_INIT = 180;
  localparam int DEF_SLIDE_STEP = 20;
  localparam int DEF_SLIDE_END  = 50;

  // A lane fires its spawner when all three of its random bits are set.
  function automatic logic lane_rand_hit(input logic [2:0] bits);
    return &bits;
  endfunction

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// Rising-edge detector that only looks at its button once per frame tick.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn,
  output logic rise
);

  logic btn_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev <= 1'b0;
    end else if (frame_tick) begin
      btn_prev <= btn;
    end
  end

  assign rise = frame_tick & btn & ~btn_prev;

endmodule

// File: rtl/game_sequencer.sv
// Frame-paced game director: intro sequence, lane tracking, spawn gating and scoring.
// Optional pause in PLAY is compiled in when GAME_SEQ_PAUSE_EN is defined.
module game_sequencer
  import game_pkg::*;
#(
  parameter int LANES      = 3,
  parameter int WIDTH      = 12,
  parameter int COUNT_INIT = DEF_COUNT_INIT,
  parameter int FADE_STEP  = DEF_FADE_STEP,
  parameter int FADE_END   = DEF_FADE_END,
  parameter int SLIDE_INIT = DEF_SLIDE_INIT,
  parameter int SLIDE_STEP = DEF_SLIDE_STEP,
  parameter int SLIDE_END  = DEF_SLIDE_END,
  parameter int LANE_PITCH = 100,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         btn_start,
  input  logic [3*LANES-1:0]           rand_in,
  input  logic [LANES-1:0]             coin_arrive,
  input  logic [LANES-1:0]             hazard_arrive,
  output logic [WIDTH-1:0]             logo_voffset,
  output logic [WIDTH-1:0]             head_hoffset,
  output logic [WIDTH-1:0]             head_voffset,
  output logic [LANES-1:0]             coin_spawn,
  output logic [LANES-1:0]             hazard_spawn,
  output logic                         coin_flip,
  output logic [2:0]                   state_o,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(LIVES+1)-1:0]   lives
);

  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int CNT_W   = (COUNT_INIT > 0) ? $clog2(COUNT_INIT + 1) : 1;
  localparam int CENTER  = (LANES - 1) / 2;

  game_state_t             state, state_next;
  logic [LANE_W-1:0]       lane;
  logic [CNT_W-1:0]        frame_cnt;
  logic [LANES-1:0]        coin_prev;
  logic [LANES-1:0]        lane_hit;
  logic                    left_rise, right_rise, start_rise;
  logic                    fade_active, slide_active;
  logic                    hazard_hit, coin_hit, play_tick;
  logic signed [WIDTH-1:0] hoff_calc;

  btn_edge u_left  (.clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn_left),  .rise(left_rise));
  btn_edge u_right (.clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn_right), .rise(right_rise));
  btn_edge u_start (.clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn_start), .rise(start_rise));

  assign fade_active  = logo_voffset < WIDTH'(FADE_END);
  assign slide_active = head_voffset > WIDTH'(SLIDE_END);
  // A hazard in the player's lane beats a coin arriving in the same cycle.
  assign hazard_hit   = (state == PLAY) && hazard_arrive[lane];
  assign coin_hit     = (state == PLAY) && coin_arrive[lane] && !hazard_arrive[lane];
  assign play_tick    = frame_tick && (state == PLAY) && (state_next == PLAY);
  assign hoff_calc    = WIDTH'((int'(lane) - CENTER) * LANE_PITCH);
  assign state_o      = state;

  always_comb begin
    lane_hit = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_hit[i] = lane_rand_hit(rand_in[3*i +: 3]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET;
    end else begin
      state <= state_next;
    end
  end

  // Losing the last life ends the game on the hit itself, not on the next tick.
  always_comb begin
    state_next = state;
    case (state)
      RESET:     if (frame_tick) state_next = COUNTDOWN;
      COUNTDOWN: if (frame_tick && frame_cnt == '0) state_next = LOGO_FADE;
      LOGO_FADE: if (frame_tick && !fade_active) state_next = SLIDE;
      SLIDE:     if (frame_tick && !slide_active) state_next = PLAY;
      PLAY: begin
        if (hazard_hit && lives == LIVES_W'(1)) begin
          state_next = GAME_OVER;
`ifdef GAME_SEQ_PAUSE_EN
        end else if (start_rise) begin
          state_next = PAUSE;
`endif
        end
      end
      GAME_OVER: if (start_rise) state_next = RESET;
`ifdef GAME_SEQ_PAUSE_EN
      PAUSE:     if (start_rise) state_next = PLAY;
`endif
      default:   state_next = RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      logo_voffset <= '0;
      head_voffset <= WIDTH'(SLIDE_INIT);
      head_hoffset <= '0;
      lane         <= LANE_W'(CENTER);
      frame_cnt    <= '0;
      coin_spawn   <= '0;
      hazard_spawn <= '0;
      coin_prev    <= '0;
      coin_flip    <= 1'b0;
      score        <= '0;
      lives        <= LIVES_W'(LIVES);
    end else begin
      coin_spawn   <= '0;
      hazard_spawn <= '0;
      head_hoffset <= hoff_calc;
      if (frame_tick) begin
        case (state)
          RESET: begin
            logo_voffset <= '0;
            head_voffset <= WIDTH'(SLIDE_INIT);
            lane         <= LANE_W'(CENTER);
            frame_cnt    <= CNT_W'(COUNT_INIT);
            coin_prev    <= '0;
            coin_flip    <= 1'b0;
            score        <= '0;
            lives        <= LIVES_W'(LIVES);
          end
          COUNTDOWN: if (frame_cnt != '0) frame_cnt <= frame_cnt - CNT_W'(1);
          LOGO_FADE: if (fade_active) logo_voffset <= logo_voffset + WIDTH'(FADE_STEP);
          SLIDE:     if (slide_active) head_voffset <= head_voffset - WIDTH'(SLIDE_STEP);
          default: ;
        endcase
      end
      // A tick that leaves PLAY (game over or pause) neither spawns nor moves the lane.
      if (play_tick) begin
        if (left_rise && !right_rise && lane != '0) begin
          lane <= lane - LANE_W'(1);
        end else if (right_rise && !left_rise && lane != LANE_W'(LANES - 1)) begin
          lane <= lane + LANE_W'(1);
        end
        coin_spawn   <= lane_hit;
        hazard_spawn <= lane_hit & ~coin_prev;
        coin_prev    <= lane_hit;
        coin_flip    <= rand_in[0];
      end
      if (hazard_hit) begin
        lives <= lives - LIVES_W'(1);
      end else if (coin_hit && score != '1) begin
        score <= score + SCORE_W'(1);
      end
    end
  end

endmodule
